// File: rtl/seg7_scan_controller.sv
// 4-digit 7-seg scan sequencer with double-buffered digits; SEG7_LEADING_ZERO_BLANK_EN darkens leading zeros.
// Latency: all outputs registered, next-state visible one cycle after the deciding edge.
// Backpressure: load_ready low while a load is pending; the pending load commits at the next frame boundary.
module seg7_scan_controller #(
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [3:0] load_a,
  input  logic [3:0] load_b,
  input  logic [3:0] load_c,
  input  logic [3:0] load_d,
  output logic [3:0] dig_a,
  output logic [3:0] dig_b,
  output logic [3:0] dig_c,
  output logic [3:0] dig_d,
  output logic [1:0] scan_sel,
  output logic [3:0] dis_which,
  output logic       frame_done
);

  typedef enum logic [1:0] {ST_OFF, ST_SHOW, ST_BLANK} state_t;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  state_t           state_q, state_n;
  logic [1:0]       idx_q, idx_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             pend_vld_q, pend_vld_n;
  logic [15:0]      pend_q, pend_n;
  logic [15:0]      dig_q, dig_n;
  logic [1:0]       sel_n;
  logic [3:0]       dis_n, lz_mask;
  logic             fd_n, ready_n, commit, accept;

  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    cnt_n   = cnt_q + CNT_W'(1);
    commit  = 1'b0;
    fd_n    = 1'b0;
    if (!en) begin
      state_n = ST_OFF;
      idx_n   = 2'd0;
      cnt_n   = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          // Leaving OFF commits pending digits but is not a reported frame.
          state_n = ST_SHOW;
          idx_n   = 2'd0;
          cnt_n   = '0;
          commit  = pend_vld_q;
        end
        ST_SHOW: begin
          if (cnt_q == DWELL_LAST) begin
            cnt_n = '0;
            if (BLANK_CYCLES == 0) begin
              idx_n  = idx_q + 2'd1;
              commit = (idx_q == 2'd3) && pend_vld_q;
              fd_n   = (idx_q == 2'd3);
            end else begin
              state_n = ST_BLANK;
            end
          end
        end
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            cnt_n   = '0;
            state_n = ST_SHOW;
            idx_n   = idx_q + 2'd1;
            commit  = (idx_q == 2'd3) && pend_vld_q;
            fd_n    = (idx_q == 2'd3);
          end
        end
        default: begin
          state_n = ST_OFF;
          idx_n   = 2'd0;
          cnt_n   = '0;
        end
      endcase
    end

    accept     = load_valid && load_ready;
    pend_n     = accept ? {load_d, load_c, load_b, load_a} : pend_q;
    pend_vld_n = accept ? 1'b1 : (commit ? 1'b0 : pend_vld_q);
    dig_n      = commit ? pend_q : dig_q;
    // Ready reopens only the cycle after the commit becomes visible.
    ready_n    = !pend_vld_q && !accept;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    lz_mask = {dig_n[15:12] == 4'd0, dig_n[15:8] == 8'd0, dig_n[15:4] == 12'd0, 1'b0};
`else
    lz_mask = 4'b0000;
`endif
    sel_n = (state_n == ST_OFF) ? 2'd0 : idx_n;
    dis_n = (state_n == ST_SHOW) ? ((4'hF ^ (4'b0001 << idx_n)) | lz_mask) : 4'hF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_OFF;
      idx_q      <= 2'd0;
      cnt_q      <= '0;
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
      dig_q      <= '0;
      scan_sel   <= 2'd0;
      dis_which  <= 4'hF;
      frame_done <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      state_q    <= state_n;
      idx_q      <= idx_n;
      cnt_q      <= cnt_n;
      pend_vld_q <= pend_vld_n;
      pend_q     <= pend_n;
      dig_q      <= dig_n;
      scan_sel   <= sel_n;
      dis_which  <= dis_n;
      frame_done <= fd_n;
      load_ready <= ready_n;
    end
  end

  assign {dig_d, dig_c, dig_b, dig_a} = dig_q;

endmodule
